ex_mem_latch: RTL and testbench

- Pipeline register between the execute stage and the data-access (memory) stage.
- Holds one instruction's datapath and control bundle, using a 2-entry skid buffer with valid/ready handshakes on both sides.
- Kills in-flight instructions when the memory stage resolves a taken branch (pcSrc).
- Gates memory-write and register-write controls with valid, so bubbles never write the data memory or the register file.

---
 rtl/ex_mem_latch_pkg.sv | 32 +++
 rtl/ex_mem_latch_skid_reg.sv | 58 +++++
 rtl/ex_mem_latch.sv | 112 +++++++++++
 tb/tb_ex_mem_latch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_latch_pkg.sv
// rtl/ex_mem_latch_pkg.sv - shared EX/MEM pipeline widths, opcodes and bundle type
package ex_mem_latch_pkg;

  localparam int B_DEF    = 32;
  localparam int W_DEF    = 5;
  localparam int OPCODE_W = 6;

  // Load/store opcodes; the memory stage decodes access width from these.
  localparam logic [OPCODE_W-1:0] LB  = 6'h20;
  localparam logic [OPCODE_W-1:0] LH  = 6'h21;
  localparam logic [OPCODE_W-1:0] LW  = 6'h23;
  localparam logic [OPCODE_W-1:0] LBU = 6'h24;
  localparam logic [OPCODE_W-1:0] LHU = 6'h25;
  localparam logic [OPCODE_W-1:0] SB  = 6'h28;
  localparam logic [OPCODE_W-1:0] SH  = 6'h29;
  localparam logic [OPCODE_W-1:0] SW  = 6'h2B;

  typedef struct packed {
    logic [B_DEF-1:0]    alu_result;
    logic [B_DEF-1:0]    write_data;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_write;
    logic                branch;
    logic                branch_not;
    logic                zero;
    logic                reg_write;
    logic                mem_to_reg;
    logic [W_DEF-1:0]    write_reg;
    logic [B_DEF-1:0]    branch_target;
  } ex_mem_bundle_t;

endpackage

// File: rtl/ex_mem_latch_skid_reg.sv
// rtl/ex_mem_latch_skid_reg.sv - generic 2-entry valid/ready skid buffer with flush
module skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             m_v;
  logic             s_v;
  logic [WIDTH-1:0] m_d;
  logic [WIDTH-1:0] s_d;
  logic             accept;
  logic             drain;

  // Ready depends only on the skid flag, so no comb path from out_ready.
  assign in_ready  = ~s_v;
  assign out_valid = m_v;
  assign out_data  = m_d;
  assign accept    = in_valid & ~s_v;
  assign drain     = m_v & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m_d <= '0;
      s_d <= '0;
    end else begin
      if (s_v) begin
        if (drain) m_d <= s_d;
      end else if (accept) begin
        if (!m_v || drain) m_d <= in_data;
        else               s_d <= in_data;
      end

      if (flush) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
      end else if (s_v) begin
        if (drain) s_v <= 1'b0;
      end else begin
        m_v <= accept | (m_v & ~drain);
        s_v <= accept & m_v & ~drain;
      end
    end
  end

  a_no_skid_without_main: assert property (@(posedge clk) disable iff (!rst_n) !(s_v && !m_v));

endmodule

// File: rtl/ex_mem_latch.sv
// rtl/ex_mem_latch.sv - EX/MEM pipeline latch; EX_MEM_STALL_COUNT_EN adds stall_count
module ex_mem_latch
  import ex_mem_latch_pkg::*;
#(
  parameter int B = B_DEF,
  parameter int W = W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [B-1:0]        ex_alu_result,
  input  logic [B-1:0]        ex_write_data,
  input  logic [OPCODE_W-1:0] ex_opcode,
  input  logic                ex_mem_write,
  input  logic                ex_branch,
  input  logic                ex_branch_not,
  input  logic                ex_zero,
  input  logic                ex_reg_write,
  input  logic                ex_mem_to_reg,
  input  logic [W-1:0]        ex_write_reg,
  input  logic [B-1:0]        ex_branch_target,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [B-1:0]        mem_alu_result,
  output logic [B-1:0]        mem_write_data,
  output logic [OPCODE_W-1:0] mem_opcode,
  output logic                mem_mem_write,
  output logic                mem_branch,
  output logic                mem_branch_not,
  output logic                mem_zero,
  output logic                mem_reg_write,
  output logic                mem_mem_to_reg,
  output logic [W-1:0]        mem_write_reg,
  output logic [B-1:0]        mem_branch_target,
`ifdef EX_MEM_STALL_COUNT_EN
  output logic [31:0]         stall_count,
`endif
  input  logic                flush
);

  // Same field order as ex_mem_bundle_t, but sized by this instance's B/W.
  typedef struct packed {
    logic [B-1:0]        alu_result;
    logic [B-1:0]        write_data;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_write;
    logic                branch;
    logic                branch_not;
    logic                zero;
    logic                reg_write;
    logic                mem_to_reg;
    logic [W-1:0]        write_reg;
    logic [B-1:0]        branch_target;
  } bundle_t;

  bundle_t ex_bundle;
  bundle_t mem_bundle;

  assign ex_bundle = '{
    alu_result:    ex_alu_result,
    write_data:    ex_write_data,
    opcode:        ex_opcode,
    mem_write:     ex_mem_write,
    branch:        ex_branch,
    branch_not:    ex_branch_not,
    zero:          ex_zero,
    reg_write:     ex_reg_write,
    mem_to_reg:    ex_mem_to_reg,
    write_reg:     ex_write_reg,
    branch_target: ex_branch_target
  };

  skid_reg #(
    .WIDTH ($bits(bundle_t))
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (ex_valid),
    .in_ready  (ex_ready),
    .in_data   (ex_bundle),
    .out_valid (mem_valid),
    .out_ready (mem_ready),
    .out_data  (mem_bundle)
  );

  assign mem_alu_result    = mem_bundle.alu_result;
  assign mem_write_data    = mem_bundle.write_data;
  assign mem_opcode        = mem_bundle.opcode;
  assign mem_zero          = mem_bundle.zero;
  assign mem_mem_to_reg    = mem_bundle.mem_to_reg;
  assign mem_write_reg     = mem_bundle.write_reg;
  assign mem_branch_target = mem_bundle.branch_target;

  // Stale data left in M after a drain or flush must never write memory or regs.
  assign mem_mem_write  = mem_bundle.mem_write  & mem_valid;
  assign mem_branch     = mem_bundle.branch     & mem_valid;
  assign mem_branch_not = mem_bundle.branch_not & mem_valid;
  assign mem_reg_write  = mem_bundle.reg_write  & mem_valid;

`ifdef EX_MEM_STALL_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (ex_valid && !ex_ready && stall_count != 32'hFFFF_FFFF) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_latch.sv
// tb/tb_ex_mem_latch.sv - directed self-checking bench for ex_mem_latch
module tb_ex_mem_latch;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_write_data;
  logic [5:0]  ex_opcode;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_branch_not;
  logic        ex_zero;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic [4:0]  ex_write_reg;
  logic [31:0] ex_branch_target;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_write_data;
  logic [5:0]  mem_opcode;
  logic        mem_mem_write;
  logic        mem_branch;
  logic        mem_branch_not;
  logic        mem_zero;
  logic        mem_reg_write;
  logic        mem_mem_to_reg;
  logic [4:0]  mem_write_reg;
  logic [31:0] mem_branch_target;
  logic        flush;
`ifdef EX_MEM_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  ex_mem_latch dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_valid          (ex_valid),
    .ex_ready          (ex_ready),
    .ex_alu_result     (ex_alu_result),
    .ex_write_data     (ex_write_data),
    .ex_opcode         (ex_opcode),
    .ex_mem_write      (ex_mem_write),
    .ex_branch         (ex_branch),
    .ex_branch_not     (ex_branch_not),
    .ex_zero           (ex_zero),
    .ex_reg_write      (ex_reg_write),
    .ex_mem_to_reg     (ex_mem_to_reg),
    .ex_write_reg      (ex_write_reg),
    .ex_branch_target  (ex_branch_target),
    .mem_valid         (mem_valid),
    .mem_ready         (mem_ready),
    .mem_alu_result    (mem_alu_result),
    .mem_write_data    (mem_write_data),
    .mem_opcode        (mem_opcode),
    .mem_mem_write     (mem_mem_write),
    .mem_branch        (mem_branch),
    .mem_branch_not    (mem_branch_not),
    .mem_zero          (mem_zero),
    .mem_reg_write     (mem_reg_write),
    .mem_mem_to_reg    (mem_mem_to_reg),
    .mem_write_reg     (mem_write_reg),
    .mem_branch_target (mem_branch_target),
`ifdef EX_MEM_STALL_COUNT_EN
    .stall_count       (stall_count),
`endif
    .flush             (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] alu, input logic [31:0] wd, input logic [5:0] op,
                         input logic mw, input logic br, input logic brn, input logic z,
                         input logic rw, input logic m2r, input logic [4:0] wr,
                         input logic [31:0] bt);
    ex_valid         = 1'b1;
    ex_alu_result    = alu;
    ex_write_data    = wd;
    ex_opcode        = op;
    ex_mem_write     = mw;
    ex_branch        = br;
    ex_branch_not    = brn;
    ex_zero          = z;
    ex_reg_write     = rw;
    ex_mem_to_reg    = m2r;
    ex_write_reg     = wr;
    ex_branch_target = bt;
  endtask

  task automatic idle();
    present(32'h0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    ex_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    mem_ready = 1'b0;
    idle();
    tick();
    tick();
    check("reset_mem_valid", mem_valid, 0);
    check("reset_alu_result", mem_alu_result, 0);
    rst_n = 1'b1;
    tick();
    check("post_reset_ex_ready", ex_ready, 1);
    check("post_reset_mem_valid", mem_valid, 0);
`ifdef EX_MEM_STALL_COUNT_EN
    check("post_reset_stall_count", stall_count, 0);
`endif

    // Streaming: one bundle per cycle, one cycle latency.
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      present(32'h100 + i, 32'h0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 32'h0);
      tick();
      check("stream_ex_ready", ex_ready, 1);
      check("stream_mem_valid", mem_valid, 1);
      check("stream_alu_result", mem_alu_result, 32'h100 + i);
    end
    idle();
    tick();
    check("stream_drained", mem_valid, 0);

    // Backpressure: A then B fill the latch, C waits behind them.
    mem_ready = 1'b0;
    present(32'hA, 32'h0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 32'h0);
    tick();
    check("bp_ready_after_a", ex_ready, 1);
    present(32'hB, 32'h0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0);
    tick();
    check("bp_ready_after_b", ex_ready, 0);
    check("bp_head_a", mem_alu_result, 32'hA);
    present(32'hC, 32'h0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0);
    tick();
    check("bp_hold_a", mem_alu_result, 32'hA);
    check("bp_hold_ready", ex_ready, 0);
    mem_ready = 1'b1;
    tick();
    check("bp_second_b", mem_alu_result, 32'hB);
    check("bp_second_wr", mem_write_reg, 3);
    check("bp_ready_reopen", ex_ready, 1);
    tick();
    check("bp_third_c", mem_alu_result, 32'hC);
    check("bp_third_valid", mem_valid, 1);
    idle();
    tick();
    check("bp_empty", mem_valid, 0);
`ifdef EX_MEM_STALL_COUNT_EN
    check("bp_stall_count", stall_count, 2);
`endif

    // Flush while FULL with two stores and a third bundle waiting.
    mem_ready = 1'b0;
    present(32'h20, 32'h11, 6'h2B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    present(32'h24, 32'h22, 6'h2B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    check("flush_pre_store", mem_mem_write, 1);
    present(32'h28, 32'h33, 6'h2B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    flush = 1'b1;
    tick();
    check("flush_mem_valid", mem_valid, 0);
    check("flush_mem_write", mem_mem_write, 0);
    check("flush_ready", ex_ready, 1);
    // A bundle accepted in the flush cycle is also dropped.
    mem_ready = 1'b1;
    present(32'h2C, 32'h44, 6'h2B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    check("flush_accept_dropped", mem_valid, 0);
    flush = 1'b0;
    idle();
    tick();
    check("flush_still_empty", mem_valid, 0);
    check("flush_no_store", mem_mem_write, 0);
`ifdef EX_MEM_STALL_COUNT_EN
    check("flush_stall_count", stall_count, 3);
`endif

    // Bubble gating: controls asserted with ex_valid low.
    ex_mem_write = 1'b1;
    ex_reg_write = 1'b1;
    tick();
    check("bubble_mem_write", mem_mem_write, 0);
    check("bubble_reg_write", mem_reg_write, 0);

    // Load bundle fields pass through intact.
    present(32'h200, 32'hDEAD, 6'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0);
    tick();
    check("lw_opcode", mem_opcode, 6'h23);
    check("lw_write_data", mem_write_data, 32'hDEAD);
    check("lw_reg_write", mem_reg_write, 1);
    check("lw_mem_to_reg", mem_mem_to_reg, 1);
    check("lw_write_reg", mem_write_reg, 9);

    // Branch passthrough.
    present(32'h0, 32'h0, 6'h04, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h40);
    tick();
    check("beq_branch", mem_branch, 1);
    check("beq_branch_not", mem_branch_not, 0);
    check("beq_zero", mem_zero, 1);
    check("beq_target", mem_branch_target, 32'h40);
    idle();
    tick();
    check("beq_gone", mem_branch, 0);

    // Reset mid-stream while FULL with two stores.
    mem_ready = 1'b0;
    present(32'h30, 32'h1, 6'h2B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    present(32'h34, 32'h2, 6'h2B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    check("rst_full_ready", ex_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", mem_valid, 0);
    check("rst_async_mem_write", mem_mem_write, 0);
    check("rst_async_alu", mem_alu_result, 0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_release_ready", ex_ready, 1);
    check("rst_release_valid", mem_valid, 0);
`ifdef EX_MEM_STALL_COUNT_EN
    check("rst_stall_count", stall_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
